// File: rtl/funcs_pipe.sv
// rtl/funcs_pipe.sv - pipelined add/sub lanes, accumulator, logic outputs and edge counter (option: FUNCS_PIPE_SAT_EN)
module funcs_pipe #(
    parameter int W     = 8,
    parameter int N     = 2,
    parameter int PIPE  = 2,
    parameter int ADD_K = 12,
    parameter int SUB_K = 34,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N*W-1:0]   a,
    input  logic [N*W-1:0]   b,
    output logic [N*W-1:0]   c,
    output logic [N*W-1:0]   d,
    output logic             out_valid,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [W-1:0]     acc_in,
    output logic [2*W-1:0]   acc,
    output logic             acc_ovf,
    input  logic             h,
    input  logic             i,
    output logic             j,
    output logic             k,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [W-1:0] ADD_C = W'(ADD_K);
    localparam logic [W-1:0] SUB_C = W'(SUB_K);

    logic [N*W-1:0] c_d;
    logic [N*W-1:0] d_d;

    // Per-lane arithmetic; lanes never carry into each other
    for (genvar n = 0; n < N; n++) begin : g_lane
`ifdef FUNCS_PIPE_SAT_EN
        logic [W:0] add_w;
        logic [W:0] sub_w;
        assign add_w = {1'b0, a[n*W +: W]} + {1'b0, ADD_C};
        assign sub_w = {1'b0, b[n*W +: W]} - {1'b0, SUB_C};
        // add carry clamps high, subtract borrow clamps low
        assign c_d[n*W +: W] = add_w[W] ? {W{1'b1}} : add_w[W-1:0];
        assign d_d[n*W +: W] = sub_w[W] ? {W{1'b0}} : sub_w[W-1:0];
`else
        assign c_d[n*W +: W] = a[n*W +: W] + ADD_C;
        assign d_d[n*W +: W] = b[n*W +: W] - SUB_C;
`endif
    end

    logic [N*W-1:0] c_q [PIPE];
    logic [N*W-1:0] d_q [PIPE];
    logic [PIPE-1:0] v_q;

    // Lane pipeline: always shifts; data registers only load behind a valid so outputs hold the last result
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int s = 0; s < PIPE; s++) begin
                c_q[s] <= '0;
                d_q[s] <= '0;
            end
        end else begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                c_q[0] <= c_d;
                d_q[0] <= d_d;
            end
            for (int s = 1; s < PIPE; s++) begin
                v_q[s] <= v_q[s-1];
                if (v_q[s-1]) begin
                    c_q[s] <= c_q[s-1];
                    d_q[s] <= d_q[s-1];
                end
            end
        end
    end

    assign c         = c_q[PIPE-1];
    assign d         = d_q[PIPE-1];
    assign out_valid = v_q[PIPE-1];

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;
    logic           ovf_q;
    logic [2*W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {{(W+1){1'b0}}, acc_in};

    // Next accumulator value; a carry out of the top bit either wraps or clamps
    always_comb begin
        acc_d = acc_sum[2*W-1:0];
`ifdef FUNCS_PIPE_SAT_EN
        if (acc_sum[2*W]) begin
            acc_d = {(2*W){1'b1}};
        end
`endif
    end

    // Accumulator with sticky overflow; clear beats enable
    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (acc_en) begin
            acc_q <= acc_d;
            if (acc_sum[2*W]) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign acc     = acc_q;
    assign acc_ovf = ovf_q;

    logic             j_q;
    logic             k_q;
    logic             h_q;
    logic [CNT_W-1:0] cnt_q;

    // Registered logic outputs and rising-edge counter on h (h_q resets low, so h high after reset counts)
    always_ff @(posedge clk) begin
        if (rst) begin
            j_q   <= 1'b0;
            k_q   <= 1'b0;
            h_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            j_q <= h ^ i;
            k_q <= h & i;
            h_q <= h;
            if (h && !h_q) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign j   = j_q;
    assign k   = k_q;
    assign cnt = cnt_q;

endmodule

// File: tb/tb_funcs_pipe.sv
// tb/tb_funcs_pipe.sv - self-checking bench for funcs_pipe
module tb_funcs_pipe;

    localparam int W     = 8;
    localparam int N     = 2;
    localparam int PIPE  = 2;
    localparam int ADD_K = 12;
    localparam int SUB_K = 34;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [N*W-1:0]   a, b, c, d;
    logic             out_valid;
    logic             acc_en, acc_clr;
    logic [W-1:0]     acc_in;
    logic [2*W-1:0]   acc;
    logic             acc_ovf;
    logic             h, i, j, k;
    logic [CNT_W-1:0] cnt;

    logic             h2;
    logic [N*W-1:0]   s_c, s_d;
    logic             s_ov, s_aovf, s_j, s_k;
    logic [2*W-1:0]   s_acc;
    logic [1:0]       s_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    funcs_pipe #(.W(W), .N(N), .PIPE(PIPE), .ADD_K(ADD_K), .SUB_K(SUB_K), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
        .out_valid(out_valid), .acc_en(acc_en), .acc_clr(acc_clr), .acc_in(acc_in),
        .acc(acc), .acc_ovf(acc_ovf), .h(h), .i(i), .j(j), .k(k), .cnt(cnt)
    );

    funcs_pipe #(.W(W), .N(N), .PIPE(PIPE), .ADD_K(ADD_K), .SUB_K(SUB_K), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(1'b0), .a('0), .b('0), .c(s_c), .d(s_d),
        .out_valid(s_ov), .acc_en(1'b0), .acc_clr(1'b0), .acc_in('0),
        .acc(s_acc), .acc_ovf(s_aovf), .h(h2), .i(1'b0), .j(s_j), .k(s_k), .cnt(s_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [N*W-1:0] lane_c(input logic [N*W-1:0] x);
        logic [N*W-1:0] r;
        int s;
        r = '0;
        for (int n = 0; n < N; n++) begin
            s = int'(x[n*W +: W]) + (ADD_K % (1 << W));
`ifdef FUNCS_PIPE_SAT_EN
            if (s > (1 << W) - 1) s = (1 << W) - 1;
`else
            s = s % (1 << W);
`endif
            r[n*W +: W] = s[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] lane_d(input logic [N*W-1:0] x);
        logic [N*W-1:0] r;
        int s;
        r = '0;
        for (int n = 0; n < N; n++) begin
            s = int'(x[n*W +: W]) - (SUB_K % (1 << W));
`ifdef FUNCS_PIPE_SAT_EN
            if (s < 0) s = 0;
`else
            if (s < 0) s = s + (1 << W);
`endif
            r[n*W +: W] = s[W-1:0];
        end
        return r;
    endfunction

    typedef struct {
        bit             v;
        logic [N*W-1:0] c;
        logic [N*W-1:0] d;
    } ent_t;

    ent_t           q[$];
    ent_t           e;
    bit             m_v, m_ovf, m_j, m_k, m_hq;
    logic [N*W-1:0] m_c, m_d;
    int             m_acc, m_cnt, s_sum;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_v = 0; m_c = '0; m_d = '0;
            m_acc = 0; m_ovf = 0;
            m_j = 0; m_k = 0; m_hq = 0; m_cnt = 0;
        end else begin
            e.v = in_valid;
            e.c = lane_c(a);
            e.d = lane_d(b);
            q.push_back(e);
            if (q.size() > PIPE) void'(q.pop_front());
            if (q.size() == PIPE) begin
                m_v = q[0].v;
                if (q[0].v) begin
                    m_c = q[0].c;
                    m_d = q[0].d;
                end
            end else begin
                m_v = 0;
            end
            if (acc_clr) begin
                m_acc = 0;
                m_ovf = 0;
            end else if (acc_en) begin
                s_sum = m_acc + int'(acc_in);
                if (s_sum >= (1 << (2*W))) begin
                    m_ovf = 1;
`ifdef FUNCS_PIPE_SAT_EN
                    s_sum = (1 << (2*W)) - 1;
`else
                    s_sum = s_sum - (1 << (2*W));
`endif
                end
                m_acc = s_sum;
            end
            if (h && !m_hq) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_hq = h;
            m_j  = h ^ i;
            m_k  = h & i;
        end
    end

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_v);
            check("c", c, m_c);
            check("d", d, m_d);
            check("acc", acc, m_acc);
            check("acc_ovf", acc_ovf, m_ovf);
            check("j", j, m_j);
            check("k", k, m_k);
            check("cnt", cnt, m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] hseq;
        rst = 1; in_valid = 0; a = '0; b = '0;
        acc_en = 0; acc_clr = 0; acc_in = '0; h = 0; i = 0; h2 = 0;
        @(posedge clk); #1 chk_en = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_d", d, 0);
        check("rst_acc", acc, 0);
        check("rst_ovf", acc_ovf, 0);
        check("rst_jk", {j, k}, 0);
        check("rst_cnt", cnt, 0);
        step(); rst = 0;

        // basic lanes: a={5,10}, b={40,100}
        in_valid = 1; a = 16'h050A; b = 16'h2864;
        step(); in_valid = 0;
        step(); @(negedge clk);
        check("lane_valid", out_valid, 1);
        check("lane_c", c, 16'h1116);
        check("lane_d", d, 16'h0642);
        check("model_lane_c", m_c, 16'h1116);
        step(); @(negedge clk);
        check("lane_hold_valid", out_valid, 0);
        check("lane_hold_c", c, 16'h1116);

        // wrap / saturation
        in_valid = 1; a = 16'hFAFA; b = 16'h0000;
        step(); in_valid = 0;
        step(); @(negedge clk);
`ifdef FUNCS_PIPE_SAT_EN
        check("wrap_c", c, 16'hFFFF);
        check("wrap_d", d, 16'h0000);
`else
        check("wrap_c", c, 16'h0606);
        check("wrap_d", d, 16'hDEDE);
`endif

        // pipeline pattern 1,0,1
        in_valid = 1; a = 16'h0101; b = 16'h6464;
        step(); in_valid = 0; a = 16'h0202;
        step(); @(negedge clk);
        check("pipe_v0", out_valid, 1);
        check("pipe_c0", c, 16'h0D0D);
        in_valid = 1; a = 16'h0303;
        step(); @(negedge clk);
        check("pipe_v1", out_valid, 0);
        check("pipe_c1", c, 16'h0D0D);
        in_valid = 0;
        step(); @(negedge clk);
        check("pipe_v2", out_valid, 1);
        check("pipe_c2", c, 16'h0F0F);

        // accumulator to 0xFFF0, then overflow
        acc_clr = 1;
        step(); acc_clr = 0; acc_en = 1; acc_in = 8'hFF;
        repeat (256) step();
        acc_in = 8'hF0;
        step(); acc_en = 0; @(negedge clk);
        check("acc_fff0", acc, 16'hFFF0);
        check("acc_fff0_ovf", acc_ovf, 0);
        check("model_acc_fff0", m_acc, 16'hFFF0);
        acc_en = 1; acc_in = 8'h20;
        step(); acc_en = 0; @(negedge clk);
`ifdef FUNCS_PIPE_SAT_EN
        check("acc_ovf_val", acc, 16'hFFFF);
`else
        check("acc_ovf_val", acc, 16'h0010);
`endif
        check("acc_ovf_set", acc_ovf, 1);
        acc_en = 1; acc_in = 8'h05;
        step(); acc_en = 0; @(negedge clk);
        check("acc_ovf_sticky", acc_ovf, 1);
        acc_en = 1; acc_clr = 1; acc_in = 8'h77;
        step(); acc_en = 0; acc_clr = 0; @(negedge clk);
        check("acc_clr_val", acc, 0);
        check("acc_clr_ovf", acc_ovf, 0);

        // edge counter and logic with i=1, h = 1,0,1,1,0
        i = 1; hseq = 5'b01101;
        for (int n = 0; n < 5; n++) begin
            h = hseq[n];
            step(); @(negedge clk);
            check("logic_j", j, hseq[n] ^ 1'b1);
            check("logic_k", k, hseq[n]);
        end
        check("edge_cnt", cnt, 2);
        i = 0;

        // narrow counter wrap: 3 edges then a 4th wraps to 0
        repeat (3) begin
            h2 = 1; step(); h2 = 0; step();
        end
        @(negedge clk);
        check("small_cnt3", s_cnt, 3);
        h2 = 1; step(); h2 = 0; step(); @(negedge clk);
        check("small_cnt_wrap", s_cnt, 0);

        // reset while a sample is in flight
        in_valid = 1; a = 16'h1234; b = 16'h5678; acc_en = 1; acc_in = 8'h09; h = 1;
        step(); rst = 1; in_valid = 0; acc_en = 0; h = 0;
        step(); @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cd", {c, d}, 0);
        check("mid_rst_acc", {acc, acc_ovf}, 0);
        check("mid_rst_misc", {j, k, cnt}, 0);
        rst = 0;
        for (int n = 0; n < 3; n++) begin
            step(); @(negedge clk);
            check("post_rst_valid", out_valid, 0);
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
